// File: rtl/hpi_access_arbiter.sv
// Two-port arbiter and access sequencer for the CY7C67200 HPI pin interface.
// Define HPI_RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module hpi_access_arbiter #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_port,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  sw_address,
  output logic [15:0] sw_data_out,
  output logic        sw_r,
  output logic        sw_w,
  output logic        sw_cs,
  input  logic [15:0] sw_data_in
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state;
  logic [3:0] phase_cnt;
  logic       lat_write;
  logic       lat_port;
  logic       grant;
  logic       xfer;

`ifdef HPI_RR_ARB_EN
  logic last_grant;

  // On a tie the port that was not served last wins.
  always_comb begin
    grant = ~req0_valid;
    if (req0_valid && req1_valid)
      grant = ~last_grant;
  end
`else
  always_comb begin
    grant = ~req0_valid;
  end
`endif

  assign req0_ready = ~Reset && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = ~Reset && (state == IDLE) && req1_valid &&  grant;
  assign xfer       = req0_ready | req1_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      phase_cnt   <= 4'd0;
      lat_write   <= 1'b0;
      lat_port    <= 1'b0;
      sw_address  <= 2'd0;
      sw_data_out <= 16'd0;
      sw_cs       <= 1'b1;
      sw_r        <= 1'b1;
      sw_w        <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_port    <= 1'b0;
      rsp_rdata   <= 16'd0;
`ifdef HPI_RR_ARB_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            lat_port    <= grant;
            lat_write   <= grant ? req1_write : req0_write;
            sw_address  <= grant ? req1_addr  : req0_addr;
            sw_data_out <= grant ? req1_wdata : req0_wdata;
            sw_cs       <= 1'b0;
            phase_cnt   <= 4'(SETUP_CYC - 1);
            state       <= SETUP;
`ifdef HPI_RR_ARB_EN
            last_grant  <= grant;
`endif
          end
        end
        SETUP: begin
          if (phase_cnt == 4'd0) begin
            phase_cnt <= 4'(STROBE_CYC - 1);
            state     <= STROBE;
            if (lat_write)
              sw_w <= 1'b0;
            else
              sw_r <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        STROBE: begin
          if (phase_cnt == 4'd0) begin
            phase_cnt <= 4'(HOLD_CYC - 1);
            state     <= HOLD;
            sw_r      <= 1'b1;
            sw_w      <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        HOLD: begin
          // Second HOLD cycle: read data has crossed the interface's output and input registers.
          if (!lat_write && (phase_cnt == 4'(HOLD_CYC - 2)))
            rsp_rdata <= sw_data_in;
          if (phase_cnt == 4'd0) begin
            state     <= IDLE;
            sw_cs     <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_port  <= lat_port;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hpi_access_arbiter.sv
// Bench for hpi_access_arbiter: directed scenarios plus randomized requesters checked
// against a cycle-offset reference model; a second instance covers non-default phase lengths.
module tb_hpi_access_arbiter;

  localparam int S = 1;
  localparam int T = 2;
  localparam int H = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        req0_valid, req0_write, req0_ready;
  logic [1:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid, req1_write, req1_ready;
  logic [1:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp_valid, rsp_port, busy;
  logic [15:0] rsp_rdata;
  logic [1:0]  sw_address;
  logic [15:0] sw_data_out, sw_data_in;
  logic        sw_r, sw_w, sw_cs;

  // Second instance: SETUP 3, STROBE 4, HOLD 2.
  logic        b_v0, b_ready0, b_ready1, b_rsp_valid, b_rsp_port, b_busy;
  logic        b_sw_r, b_sw_w, b_sw_cs;
  logic [15:0] b_rsp_rdata, b_sw_data_out, b_din;
  logic [1:0]  b_sw_address;

  always #5 Clk = ~Clk;

  hpi_access_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_rdata(rsp_rdata), .busy(busy),
    .sw_address(sw_address), .sw_data_out(sw_data_out),
    .sw_r(sw_r), .sw_w(sw_w), .sw_cs(sw_cs), .sw_data_in(sw_data_in)
  );

  hpi_access_arbiter #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) dut2 (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(b_v0), .req0_write(1'b0), .req0_addr(2'd1),
    .req0_wdata(16'h0000), .req0_ready(b_ready0),
    .req1_valid(1'b0), .req1_write(1'b0), .req1_addr(2'd0),
    .req1_wdata(16'h0000), .req1_ready(b_ready1),
    .rsp_valid(b_rsp_valid), .rsp_port(b_rsp_port), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
    .sw_address(b_sw_address), .sw_data_out(b_sw_data_out),
    .sw_r(b_sw_r), .sw_w(b_sw_w), .sw_cs(b_sw_cs), .sw_data_in(b_din)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: everything is derived from the cycle offset since the last transfer.
  int          cyc;
  int          t_x;
  int          n_txn;
  logic        m_port, m_write, m_last, m_rsp_port;
  logic [1:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic        gnt0, gnt1;
  int          log_port[$];
  int          log_cyc[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    t_x = -1; m_port = 0; m_write = 0; m_last = 1; m_rsp_port = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; gnt0 = 0; gnt1 = 0; cyc = 0;
  endtask

  task automatic check_and_update();
    int rel;
    bit has, active, win1, g0, g1;
    has    = (t_x >= 0);
    rel    = cyc - t_x;
    active = has && rel >= 1 && rel <= S + T + H;
`ifdef HPI_RR_ARB_EN
    win1 = !m_last;
`else
    win1 = 1'b0;
`endif
    g0 = !active && req0_valid && (!req1_valid || !win1);
    g1 = !active && req1_valid && (!req0_valid || win1);
    chk("req0_ready", 16'(req0_ready), 16'(g0));
    chk("req1_ready", 16'(req1_ready), 16'(g1));
    chk("sw_cs", 16'(sw_cs), 16'(!active));
    chk("sw_r", 16'(sw_r), 16'(!(active && !m_write && rel >= S + 1 && rel <= S + T)));
    chk("sw_w", 16'(sw_w), 16'(!(active &&  m_write && rel >= S + 1 && rel <= S + T)));
    chk("sw_address", 16'(sw_address), 16'(m_addr));
    chk("sw_data_out", sw_data_out, m_wdata);
    chk("rsp_valid", 16'(rsp_valid), 16'(has && rel == S + T + H + 1));
    chk("rsp_port", 16'(rsp_port), 16'(m_rsp_port));
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("busy", 16'(busy), 16'(active));
    if (has && !m_write && rel == S + T + 2) m_rdata = sw_data_in;
    if (has && rel == S + T + H) m_rsp_port = m_port;
    gnt0 = g0;
    gnt1 = g1;
    if (g0 || g1) begin
      m_port  = g1;
      m_write = g1 ? req1_write : req0_write;
      m_addr  = g1 ? req1_addr  : req0_addr;
      m_wdata = g1 ? req1_wdata : req0_wdata;
      m_last  = g1;
      t_x     = cyc;
      n_txn++;
      log_port.push_back(int'(g1));
      log_cyc.push_back(cyc);
      $display("txn %0d: cycle %0d port %0d %s addr %0d wdata %h", n_txn, cyc, g1,
               m_write ? "write" : "read", m_addr, m_wdata);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    check_and_update();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic idle_ticks(input int n);
    req0_valid = 0;
    req1_valid = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int base;
    Reset = 1;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    sw_data_in = 0; b_v0 = 0; b_din = 0; n_txn = 0;
    model_reset();
    #2;
    chk("reset_sw_cs", 16'(sw_cs), 16'd1);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_rsp_valid", 16'(rsp_valid), 16'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 0;
    @(posedge Clk);
    #1;

    // Port 0 writes 0x1234 to ADDRESS.
    req0_valid = 1; req0_write = 1; req0_addr = 2; req0_wdata = 16'h1234;
    tick();
    idle_ticks(7);

    // Port 1 reads DATA; 0xBEEF appears on sw_data_in from cycle 4.
    req1_valid = 1; req1_write = 0; req1_addr = 0; req1_wdata = 16'h5555;
    sw_data_in = 16'h0bad;
    tick();
    req1_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c >= 4) sw_data_in = 16'hBEEF;
      tick();
    end
    chk("read_beef", rsp_rdata, 16'hBEEF);
    idle_ticks(2);

    // Both ports request continuously for four transactions.
    base = log_port.size();
    req0_valid = 1; req0_write = 1; req0_addr = 1; req0_wdata = 16'hA000;
    req1_valid = 1; req1_write = 1; req1_addr = 3; req1_wdata = 16'hB000;
    cyc = 0;
    for (int i = 0; i < 19; i++) tick();
    for (int i = 0; i < 4; i++) begin
`ifdef HPI_RR_ARB_EN
      chk("tie_grant", 16'(log_port[base + i]), 16'(i % 2));
`else
      chk("tie_grant", 16'(log_port[base + i]), 16'd0);
`endif
      chk("tie_cycle", 16'(log_cyc[base + i]), 16'(6 * i));
    end
    idle_ticks(7);

    // Reset in cycle 2 of a write drops it without a completion.
    req0_valid = 1; req0_write = 1; req0_addr = 3; req0_wdata = 16'hC0DE;
    tick();
    req0_valid = 0;
    tick();
    req0_valid = 1; req1_valid = 1;
    Reset = 1;
    #1;
    chk("rst_sw_cs", 16'(sw_cs), 16'd1);
    chk("rst_sw_w", 16'(sw_w), 16'd1);
    chk("rst_sw_r", 16'(sw_r), 16'd1);
    chk("rst_ready0", 16'(req0_ready), 16'd0);
    chk("rst_ready1", 16'(req1_ready), 16'd0);
    chk("rst_addr", 16'(sw_address), 16'd0);
    chk("rst_data", sw_data_out, 16'd0);
    @(posedge Clk);
    #1;
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    req0_valid = 0; req1_valid = 0;
    @(negedge Clk);
    Reset = 0;
    @(posedge Clk);
    #1;
    model_reset();
    req0_valid = 1; req1_valid = 1;
    req0_write = 0; req0_addr = 1; req1_write = 1; req1_addr = 2;
    base = log_port.size();
    tick();
    chk("post_rst_port", 16'(log_port[base]), 16'd0);
    idle_ticks(7);

    // Randomized requesters obeying the hold-until-ready rule.
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || gnt0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_write = 1'($urandom); req0_addr = 2'($urandom); req0_wdata = 16'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 0;
      end
      if (!req1_valid || gnt1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_write = 1'($urandom); req1_addr = 2'($urandom); req1_wdata = 16'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 0;
      end
      sw_data_in = 16'($urandom);
      tick();
    end
    idle_ticks(7);

    // Longer phases: read strobe in cycles 4-7, capture end of cycle 9, completion in cycle 10.
    b_v0 = 1;
    for (int c = 0; c <= 11; c++) begin
      b_din = 16'h1000 + 16'(c);
      @(negedge Clk);
      if (c == 0) chk("b_ready0", 16'(b_ready0), 16'd1);
      chk("b_sw_cs", 16'(b_sw_cs), 16'(!(c >= 1 && c <= 9)));
      chk("b_sw_r", 16'(b_sw_r), 16'(!(c >= 4 && c <= 7)));
      chk("b_rsp_valid", 16'(b_rsp_valid), 16'(c == 10));
      if (c == 10) chk("b_rsp_rdata", b_rsp_rdata, 16'h1009);
      @(posedge Clk);
      #1;
      b_v0 = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
